// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
//  Shared types and constants for the AHB-Lite to APB3 bridge.
//  - bridge_state_e : bridge FSM states
//  - HTRANS_*       : AHB transfer type encodings
//  - HRESP_*        : AHB response encodings
//  - idx_width()    : slave index width, at least 1 bit
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
//  Combinational address map: equal-sized slave windows starting at SLV_BASE.
//  Ports:
//   i_haddr  in  ADDR_W  AHB address
//   o_idx    out IDX_W   slave index (valid only when o_mapped)
//   o_mapped out 1       address falls inside one of the NUM_SLV windows
// ---------------------------------------------------------------------------
module apb_addr_decoder
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W        = 32,
   parameter int                NUM_SLV       = 4,
   parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
   parameter int                SLV_SIZE_LOG2 = 26,
   parameter int                IDX_W         = idx_width(NUM_SLV)
) (
   input  logic [ADDR_W-1:0] i_haddr,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_mapped
);

   logic [ADDR_W-1:0] w_off;
   logic [ADDR_W-1:0] w_win;

   // Below-base addresses wrap to a huge window number; the >= test
   // rejects them explicitly rather than relying on that wrap.
   assign w_off    = i_haddr - SLV_BASE;
   assign w_win    = w_off >> SLV_SIZE_LOG2;
   assign o_idx    = w_win[IDX_W-1:0];
   assign o_mapped = (i_haddr >= SLV_BASE) && (w_win < ADDR_W'(NUM_SLV));

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_nslv
//  AHB-Lite slave to APB3 master bridge for NUM_SLV peripherals with PREADY
//  wait states, PSLVERR / unmapped error responses, PREADY timeout and
//  back-to-back acceptance on the completing ACCESS cycle.
//  Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_hwrite, i_hreadyin,
//   i_htrans, i_haddr, i_hwdata  AHB address/data phase inputs
//   o_hrdata, o_hreadyout,
//   o_hresp                      AHB response
//   o_pselx, o_paddr, o_pwdata,
//   o_pwrite, o_penable          APB request
//   i_pready, i_pslverr,
//   i_prdata                     APB response from selected slave
// ---------------------------------------------------------------------------
module ahb_apb_bridge_nslv
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W        = 32,
   parameter int                DATA_W        = 32,
   parameter int                NUM_SLV       = 4,
   parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
   parameter int                SLV_SIZE_LOG2 = 26,
   parameter int                TIMEOUT       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_hwrite,
   input  logic               i_hreadyin,
   input  logic [1:0]         i_htrans,
   input  logic [ADDR_W-1:0]  i_haddr,
   input  logic [DATA_W-1:0]  i_hwdata,
   output logic [DATA_W-1:0]  o_hrdata,
   output logic               o_hreadyout,
   output logic [1:0]         o_hresp,
   output logic [NUM_SLV-1:0] o_pselx,
   output logic [ADDR_W-1:0]  o_paddr,
   output logic [DATA_W-1:0]  o_pwdata,
   output logic               o_pwrite,
   output logic               o_penable,
   input  logic               i_pready,
   input  logic               i_pslverr,
   input  logic [DATA_W-1:0]  i_prdata
);

   localparam int IDX_W = idx_width(NUM_SLV);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   bridge_state_e     r_state, w_next, w_dst;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_pwrite;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;

   logic [IDX_W-1:0]  w_idx;
   logic              w_mapped;
   logic              w_valid;
   logic              w_ok_done;
   logic              w_take;
   logic              w_timeout;
   logic              w_sel_on;

   apb_addr_decoder #(
      .ADDR_W        (ADDR_W),
      .NUM_SLV       (NUM_SLV),
      .SLV_BASE      (SLV_BASE),
      .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
      .IDX_W         (IDX_W)
   ) u_dec (
      .i_haddr  (i_haddr),
      .o_idx    (w_idx),
      .o_mapped (w_mapped)
   );

   assign w_valid   = i_hreadyin && i_htrans[1];
   assign w_ok_done = (r_state == ST_ACCESS) && i_pready && !i_pslverr;
   // A new transfer can only be taken when the bridge is driving HREADY high.
   assign w_take    = w_valid && ((r_state == ST_IDLE) || (r_state == ST_ERR2) || w_ok_done);
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_dst     = !w_mapped ? ST_ERR1 : (i_hwrite ? ST_WWAIT : ST_SETUP);

   always_comb begin
      w_next      = r_state;
      o_hreadyout = 1'b1;
      o_hresp     = HRESP_OKAY;
      o_penable   = 1'b0;
      w_sel_on    = 1'b0;
      case (r_state)
         ST_IDLE: if (w_take) w_next = w_dst;
         ST_WWAIT: begin
            o_hreadyout = 1'b0;
            w_next      = ST_SETUP;
         end
         ST_SETUP: begin
            o_hreadyout = 1'b0;
            w_sel_on    = 1'b1;
            w_next      = ST_ACCESS;
         end
         ST_ACCESS: begin
            w_sel_on  = 1'b1;
            o_penable = 1'b1;
            if (!i_pready) begin
               o_hreadyout = 1'b0;
               if (w_timeout) w_next = ST_ERR1;
            end else if (i_pslverr) begin
               o_hreadyout = 1'b0;
               w_next      = ST_ERR1;
            end else begin
               w_next = w_take ? w_dst : ST_IDLE;
            end
         end
         ST_ERR1: begin
            o_hresp     = HRESP_ERROR;
            o_hreadyout = 1'b0;
            w_next      = ST_ERR2;
         end
         ST_ERR2: begin
            o_hresp = HRESP_ERROR;
            w_next  = w_take ? w_dst : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign o_pselx  = w_sel_on ? (NUM_SLV'(1) << r_idx) : '0;
   assign o_paddr  = r_paddr;
   assign o_pwdata = r_pwdata;
   assign o_pwrite = r_pwrite;
   // Read data is only passed through on the single cycle the read completes.
   assign o_hrdata = (w_ok_done && !r_pwrite) ? i_prdata : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pwrite <= 1'b0;
         r_idx    <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_paddr  <= i_haddr;
            r_pwrite <= i_hwrite;
            r_idx    <= w_idx;
         end
         // Write data arrives one cycle after the address phase.
         if (r_state == ST_WWAIT) r_pwdata <= i_hwdata;
         // SETUP is only ever entered from another state, so this is entry.
         if (w_next == ST_SETUP)
            r_cnt <= '0;
         else if ((r_state == ST_ACCESS) && !i_pready)
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge_nslv
//  Scoreboard bench: the driver pushes the expected AHB completion and APB
//  transfer for each issued transaction; a negedge monitor pops and compares
//  them when the bridge completes. A small APB slave model supplies wait
//  states, errors and read data.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_nslv;

   localparam int TO = 16;

   logic        clk, rst;
   logic        hwrite, hreadyin, hblk;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [3:0]  pselx;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, penable, pready, pslverr;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          low;
      int          pen;
      int          sel;
   } ahb_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        wr;
      logic [31:0] wdata;
   } apb_exp_t;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];
   int n_run, n_fail;

   // AHB HREADY is the bridge's own HREADYOUT unless deliberately blocked.
   assign hreadyin = hreadyout && !hblk;

   ahb_apb_bridge_nslv #(
      .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_BASE(32'h8000_0000),
      .SLV_SIZE_LOG2(26), .TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_hwrite(hwrite), .i_hreadyin(hreadyin),
      .i_htrans(htrans), .i_haddr(haddr), .i_hwdata(hwdata),
      .o_hrdata(hrdata), .o_hreadyout(hreadyout), .o_hresp(hresp),
      .o_pselx(pselx), .o_paddr(paddr), .o_pwdata(pwdata),
      .o_pwrite(pwrite), .o_penable(penable),
      .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // APB slave model: Pready after slv_wait ACCESS cycles.
   int          slv_wait, acc_n;
   logic        slv_err;
   logic [31:0] slv_rdata;
   always @(posedge clk) begin
      #1;
      if (penable) begin
         pready  = (acc_n == slv_wait);
         pslverr = pready && slv_err;
         prdata  = pready ? slv_rdata : $urandom;
         acc_n++;
      end else begin
         acc_n   = 0;
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = $urandom;
      end
   end

   // Monitor
   logic        pend, unstable, seen_sel;
   int          low_n, pen_n, sel_n;
   logic [31:0] last_addr;
   logic [3:0]  last_sel;
   logic [1:0]  low_hresp;
   ahb_exp_t    mon_e;
   apb_exp_t    mon_a;

   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (penable) pen_n++;
            if (pselx != 4'd0) begin
               sel_n++;
               if (seen_sel && (paddr != last_addr || pselx != last_sel)) unstable = 1'b1;
               seen_sel  = 1'b1;
               last_addr = paddr;
               last_sel  = pselx;
            end
            if (penable && pready) begin
               if (apb_q.size() == 0) chk("apb_q_empty", 1, 0);
               else begin
                  mon_a = apb_q.pop_front();
                  chk("paddr", paddr, mon_a.addr);
                  chk("pselx", pselx, mon_a.sel);
                  chk("pwrite", pwrite, mon_a.wr);
                  if (mon_a.wr) chk("pwdata", pwdata, mon_a.wdata);
               end
            end
            if (!hreadyout) begin
               low_n++;
               low_hresp = hresp;
            end else begin
               if (ahb_q.size() == 0) chk("ahb_q_empty", 1, 0);
               else begin
                  mon_e = ahb_q.pop_front();
                  chk("hresp", hresp, mon_e.err ? 2'b01 : 2'b00);
                  chk("hresp_low", low_hresp, mon_e.err ? 2'b01 : 2'b00);
                  chk("hrdata", hrdata, mon_e.data);
                  chk("low_cyc", low_n, mon_e.low);
                  chk("pen_cyc", pen_n, mon_e.pen);
                  chk("sel_cyc", sel_n, mon_e.sel);
                  chk("stable", unstable, 0);
               end
               pend = 1'b0;
            end
         end
         if (hreadyin && htrans[1]) begin
            pend = 1'b1; low_n = 0; pen_n = 0; sel_n = 0;
            unstable = 1'b0; seen_sel = 1'b0; low_hresp = 2'b00;
         end
      end
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, input logic err,
                        input logic track);
      ahb_exp_t e;
      apb_exp_t a;
      logic     mapped, to, fail;
      int       idx, acc, k;
      mapped = (addr >= 32'h8000_0000) && (((addr - 32'h8000_0000) >> 26) < 32'd4);
      idx    = int'((addr - 32'h8000_0000) >> 26);
      to     = (waits >= TO);
      acc    = to ? TO : waits + 1;
      fail   = to || err;
      if (!mapped) begin
         e.err = 1'b1; e.low = 1; e.pen = 0; e.sel = 0;
      end else begin
         e.err = fail;
         e.pen = acc;
         e.sel = acc + 1;
         e.low = (wr ? 1 : 0) + 1 + (fail ? acc : acc - 1) + (fail ? 1 : 0);
      end
      e.data = (mapped && !wr && !fail) ? rd : 32'd0;
      if (track) begin
         ahb_q.push_back(e);
         if (mapped && !to) begin
            a.addr = addr; a.sel = 4'(1 << idx); a.wr = wr; a.wdata = wd;
            apb_q.push_back(a);
         end
      end
      slv_wait = waits; slv_err = err; slv_rdata = rd;
      @(posedge clk); #1;
      haddr = addr; hwrite = wr; htrans = 2'b10;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (hreadyout) break;
      end
      if (k == 100) chk("accept_timeout", 1, 0);
      @(posedge clk); #1;
      htrans = 2'b00; hwdata = wd;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && (ahb_q.size() != 0 || pend); k++) @(posedge clk);
      chk("drain", ahb_q.size(), 0);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_pselx"}, pselx, 0);
      chk({pfx, "_penable"}, penable, 0);
      chk({pfx, "_pwrite"}, pwrite, 0);
      chk({pfx, "_paddr"}, paddr, 0);
      chk({pfx, "_pwdata"}, pwdata, 0);
      chk({pfx, "_hreadyout"}, hreadyout, 1);
      chk({pfx, "_hresp"}, hresp, 0);
      chk({pfx, "_hrdata"}, hrdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      n_run = 0; n_fail = 0; pend = 1'b0;
      rst = 1'b1; hblk = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hwdata = '0;
      slv_wait = 0; slv_err = 1'b0; slv_rdata = '0; acc_n = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst0");
      @(posedge clk); #1 rst = 1'b0;

      issue(0, 32'h8400_0010, 32'h0, 32'hCAFE_0001, 0, 0, 1); drain();
      issue(1, 32'h8000_0004, 32'h1234_5678, 32'h0, 0, 0, 1); drain();
      issue(0, 32'h8C00_0020, 32'h0, 32'hA5A5_0003, 3, 0, 1); drain();
      issue(0, 32'h9000_0000, 32'h0, 32'h1111_1111, 0, 0, 1); drain();
      issue(1, 32'h7FFF_FFFC, 32'h2222_2222, 32'h0, 0, 0, 1); drain();
      issue(0, 32'h8FFF_FFFC, 32'h0, 32'h1357_9BDF, 0, 0, 1); drain();
      issue(0, 32'h8000_0100, 32'h0, 32'h4444_4444, 0, 1, 1); drain();
      issue(1, 32'h8400_0000, 32'h5555_AAAA, 32'h0, 2, 1, 1); drain();
      issue(0, 32'h8800_0008, 32'h0, 32'h6666_6666, 1000, 0, 1); drain();

      // Back-to-back: read presented during the write's data phase.
      issue(1, 32'h8800_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 1);
      issue(0, 32'h8400_0044, 32'h0, 32'h7777_0001, 0, 0, 1);
      drain();

      // BUSY and blocked HREADY are never accepted.
      @(posedge clk); #1;
      haddr = 32'h8000_0000; hwrite = 1'b0; htrans = 2'b01;
      repeat (3) begin
         @(negedge clk);
         chk("busy_pselx", pselx, 0);
         chk("busy_hready", hreadyout, 1);
      end
      @(posedge clk); #1;
      hblk = 1'b1; htrans = 2'b10;
      repeat (3) begin
         @(negedge clk);
         chk("blk_pselx", pselx, 0);
         chk("blk_hresp", hresp, 0);
      end
      @(posedge clk); #1;
      htrans = 2'b00; hblk = 1'b0;

      // Random mapped traffic.
      for (int i = 0; i < 8; i++) begin
         ra = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 26) + ($urandom & 32'h03FF_FFFC);
         issue(1'($urandom_range(0, 1)), ra, $urandom, $urandom, $urandom_range(0, 4), 0, 1);
         drain();
      end

      // Reset while stuck in ACCESS.
      issue(1, 32'h8800_0000, 32'h9999_0000, 32'h0, 1000, 0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst_acc");
      @(posedge clk); #1 rst = 1'b0;

      issue(0, 32'h8C00_0000, 32'h0, 32'hFACE_0002, 0, 0, 1); drain();

      chk("apb_q_left", apb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
